// File: rtl/dac_wave_pkg.sv
// Shared encodings and the elaboration-time sine table generator for the
// multi-channel SPI DAC waveform generator.
package dac_wave_pkg;

  localparam logic [1:0] MODE_SINE = 2'd0;
  localparam logic [1:0] MODE_SAW  = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_SQR  = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Entry k of a 2^aw sine table scaled to (2^dw-1)/2*(1+sin), rounded half up.
  // Integer Q30 Taylor series keeps it tool-neutral; quadrant points are exact.
  function automatic int sine_entry(input int k, input int aw, input int dw);
    longint s_one;
    longint pi_q;
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint num;
    int     q;
    int     j;
    bit     neg;
    s_one = 64'sd1073741824;
    pi_q  = 64'sd3373259426;
    q     = (32'sd1 << aw) / 32'sd4;
    if (k < q) begin
      j = k;
      neg = 1'b0;
    end else if (k < 32'sd2 * q) begin
      j = 32'sd2 * q - k;
      neg = 1'b0;
    end else if (k < 32'sd3 * q) begin
      j = k - 32'sd2 * q;
      neg = 1'b1;
    end else begin
      j = 32'sd4 * q - k;
      neg = 1'b1;
    end
    if (j == q) begin
      acc = s_one;
    end else begin
      x    = (pi_q * longint'(j)) >>> (aw - 32'sd1);
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n < 12; n++) begin
        term = -((term * x2) >>> 30) / longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
        acc  = acc + term;
      end
    end
    if (neg) begin
      acc = -acc;
    end
    num = longint'((32'sd1 << dw) - 32'sd1) * (s_one + acc) + s_one;
    return int'(num / (64'sd2 * s_one));
  endfunction

endpackage

// File: rtl/dac_wave_sample.sv
// Combinational phase + mode to DAC sample conversion for one channel,
// including the generated sine ROM.
module dac_wave_sample
  import dac_wave_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int PHASE_W = 16,
  parameter int ROM_AW  = 4
) (
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [1:0]         mode_i,
  output logic [DATA_W-1:0]  sample_o
);

  logic [DATA_W-1:0] rom_s [2**ROM_AW];
  logic              unused_phase_s;

  for (genvar g = 0; g < 2**ROM_AW; g++) begin : g_rom
    assign rom_s[g] = DATA_W'(sine_entry(g, ROM_AW, DATA_W));
  end

  // Low phase bits only matter for finer tables or wider samples.
  assign unused_phase_s = &{1'b0, phase_i};

  // Waveform select
  always_comb begin
    case (mode_i)
      MODE_SINE: sample_o = rom_s[phase_i[PHASE_W-1 -: ROM_AW]];
      MODE_SAW:  sample_o = phase_i[PHASE_W-1 -: DATA_W];
      MODE_TRI:  sample_o = phase_i[PHASE_W-1] ? ~phase_i[PHASE_W-2 -: DATA_W]
                                               :  phase_i[PHASE_W-2 -: DATA_W];
      MODE_SQR:  sample_o = {DATA_W{phase_i[PHASE_W-1]}};
      default:   sample_o = '0;
    endcase
  end

endmodule

// File: rtl/dac_wave_gen.sv
// Multi-channel SPI DAC waveform generator: per-channel phase accumulators,
// shared CS/SCK framing and one DIN line per channel, one frame per sample period.
module dac_wave_gen
  import dac_wave_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int DATA_W       = 12,
  parameter int CTRL_W       = 4,
  parameter int PHASE_W      = 16,
  parameter int ROM_AW       = 4,
  parameter int CLK_DIV      = 5,
  parameter int FRAME_CYCLES = 1000
) (
  input  logic                        clk_fpga,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [2*CHANNELS-1:0]       mode,
  input  logic [PHASE_W*CHANNELS-1:0] step,
  output logic                        CS,
  output logic                        SCK,
  output logic [CHANNELS-1:0]         DIN,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int FRAME_W = CTRL_W + DATA_W;
  localparam int FCNT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  logic [1:0]         state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PHASE_W-1:0] phase_q [CHANNELS];
  logic [PHASE_W-1:0] phase_d [CHANNELS];
  logic [PHASE_W-1:0] step_q  [CHANNELS];
  logic [PHASE_W-1:0] step_d  [CHANNELS];
  logic [FRAME_W-1:0] shreg_q [CHANNELS];
  logic [FRAME_W-1:0] shreg_d [CHANNELS];
  logic [DATA_W-1:0]  sample_s [CHANNELS];
  logic               tick_s;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    dac_wave_sample #(
      .DATA_W  (DATA_W),
      .PHASE_W (PHASE_W),
      .ROM_AW  (ROM_AW)
    ) u_sample (
      .phase_i  (phase_q[c]),
      .mode_i   (mode[2*c +: 2]),
      .sample_o (sample_s[c])
    );
    assign DIN[c] = shreg_q[c][FRAME_W-1];
  end

  assign tick_s     = (div_q == DIV_W'(CLK_DIV - 1));
  assign CS         = cs_q;
  assign SCK        = sck_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  // Sample-period counter, free-running while out of reset
  always_comb begin
    if (fcnt_q == FCNT_W'(FRAME_CYCLES - 1)) begin
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  // Frame FSM with SCK divider; DIN moves only on SCK rising edges
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    done_d  = 1'b0;
    phase_d = phase_q;
    step_d  = step_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && (fcnt_q == '0)) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        cs_d    = 1'b0;
        sck_d   = 1'b1;
        div_d   = '0;
        bit_d   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
          step_d[c]  = step[PHASE_W*c +: PHASE_W];
          shreg_d[c] = {{CTRL_W{1'b0}}, sample_s[c]};
        end
      end
      ST_SHIFT: begin
        if (!tick_s) begin
          div_d = div_q + DIV_W'(1);
        end else if (sck_q) begin
          div_d = '0;
          sck_d = 1'b0;
          bit_d = bit_q + BIT_W'(1);
        end else if (bit_q == BIT_W'(FRAME_W)) begin
          div_d   = '0;
          state_d = ST_DONE;
          cs_d    = 1'b1;
          sck_d   = 1'b1;
          for (int c = 0; c < CHANNELS; c++) begin
            shreg_d[c] = '0;
          end
        end else begin
          div_d = '0;
          sck_d = 1'b1;
          for (int c = 0; c < CHANNELS; c++) begin
            shreg_d[c] = shreg_q[c] << 1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          phase_d[c] = phase_q[c] + step_q[c];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        phase_q[c] <= '0;
        step_q[c]  <= '0;
        shreg_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed, table-driven bench for dac_wave_gen: decodes each SPI frame from
// the pins, checks data, SCK/DIN timing, frame period and handshake pulses.
module tb_dac_wave_gen;

  localparam int PER = 10;

  logic        clk_fpga = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [3:0]  mode;
  logic [31:0] step;
  logic        CS;
  logic        SCK;
  logic [1:0]  DIN;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  dac_wave_gen dut (
    .clk_fpga   (clk_fpga),
    .reset_n    (reset_n),
    .enable     (enable),
    .mode       (mode),
    .step       (step),
    .CS         (CS),
    .SCK        (SCK),
    .DIN        (DIN),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk_fpga = ~clk_fpga;

  typedef struct {
    logic        rst;
    logic [1:0]  m0;
    logic [1:0]  m1;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [11:0] e0;
    logic [11:0] e1;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic rst, input logic [1:0] m0, input logic [1:0] m1,
                     input logic [15:0] s0, input logic [15:0] s1,
                     input logic [11:0] e0, input logic [11:0] e1);
    vec_t v;
    v.rst = rst; v.m0 = m0; v.m1 = m1; v.s0 = s0; v.s1 = s1; v.e0 = e0; v.e1 = e1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_fpga);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_fpga);
    reset_n = 1'b1;
  endtask

  // Waits for CS low, then decodes one frame sampled on clock falling edges.
  task automatic capture(output logic [15:0] w0, output logic [15:0] w1,
                         output int low, output int falls, output int bad,
                         output int hs_bad, output logic tmo, output time tfall);
    int guard;
    int since;
    logic psck;
    logic [1:0] pdin;
    w0 = '0; w1 = '0; low = 0; falls = 0; bad = 0; hs_bad = 0; tmo = 1'b0; tfall = 0;
    guard = 0;
    while (CS !== 1'b0 && guard < 3000) begin
      @(negedge clk_fpga);
      guard++;
    end
    if (CS !== 1'b0) begin
      tmo = 1'b1;
    end else begin
      tfall = $time;
      if (busy !== 1'b1) hs_bad++;
      psck = SCK; pdin = DIN; since = 0;
      while (CS === 1'b0 && low < 400) begin
        low++;
        if (psck === 1'b1 && SCK === 1'b0) begin
          falls++;
          w0 = {w0[14:0], DIN[0]};
          w1 = {w1[14:0], DIN[1]};
          if (since != 5 || DIN !== pdin) bad++;
          since = 0;
        end else if (psck === 1'b0 && SCK === 1'b1) begin
          if (since != 5) bad++;
          since = 0;
        end else if (DIN !== pdin) begin
          bad++;
        end
        psck = SCK; pdin = DIN;
        @(negedge clk_fpga);
        since++;
      end
      if (SCK !== 1'b1 || DIN !== 2'b00 || frame_done !== 1'b0) hs_bad++;
      @(negedge clk_fpga);
      if (frame_done !== 1'b1) hs_bad++;
      @(negedge clk_fpga);
      if (frame_done !== 1'b0 || busy !== 1'b0) hs_bad++;
    end
  endtask

  logic [11:0] sine_tbl [13];
  logic [15:0] w0, w1;
  int          low, falls, bad, hs, g, seen;
  logic        tmo;
  time         tf, tprev, tdrop;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    mode    = 4'h0;
    step    = 32'h0;
    sine_tbl = '{12'h800, 12'hB0F, 12'hDA7, 12'hF63, 12'hFFF, 12'hF63, 12'hDA7,
                 12'hB0F, 12'h800, 12'h4F0, 12'h258, 12'h09C, 12'h000};
    repeat (2) @(negedge clk_fpga);
    check("rst CS", {63'd0, CS}, 64'd1);
    check("rst SCK", {63'd0, SCK}, 64'd1);
    check("rst DIN", {62'd0, DIN}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst frame_done", {63'd0, frame_done}, 64'd0);

    // ch0 sine 0x1000 / ch1 sawtooth 0x0100 from phase 0
    for (int k = 0; k < 13; k++) begin
      add((k == 0), 2'd0, 2'd1, 16'h1000, 16'h0100, sine_tbl[k], 12'(16 * k));
    end
    // ch0 square 0x8000 / ch1 triangle 0x4000
    add(1'b1, 2'd3, 2'd2, 16'h8000, 16'h4000, 12'h000, 12'h000);
    add(1'b0, 2'd3, 2'd2, 16'h8000, 16'h4000, 12'hFFF, 12'h800);
    add(1'b0, 2'd3, 2'd2, 16'h8000, 16'h4000, 12'h000, 12'hFFF);
    add(1'b0, 2'd3, 2'd2, 16'h8000, 16'h4000, 12'hFFF, 12'h7FF);
    // ch0 sawtooth wrapping through 2^16 via a large step; ch1 square 0x4000
    add(1'b1, 2'd1, 2'd3, 16'h0100, 16'h4000, 12'h000, 12'h000);
    add(1'b0, 2'd1, 2'd3, 16'h0100, 16'h4000, 12'h010, 12'h000);
    add(1'b0, 2'd1, 2'd3, 16'hFD00, 16'h4000, 12'h020, 12'hFFF);
    add(1'b0, 2'd1, 2'd3, 16'h0100, 16'h4000, 12'hFF0, 12'hFFF);
    add(1'b0, 2'd1, 2'd3, 16'h0100, 16'h4000, 12'h000, 12'h000);

    enable = 1'b1;
    tprev = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      mode = {vecs[i].m1, vecs[i].m0};
      step = {vecs[i].s1, vecs[i].s0};
      if (vecs[i].rst) do_reset();
      capture(w0, w1, low, falls, bad, hs, tmo, tf);
      check($sformatf("row%0d timeout", i), {63'd0, tmo}, 64'd0);
      check($sformatf("row%0d ch0", i), {48'd0, w0}, {52'd0, vecs[i].e0});
      check($sformatf("row%0d ch1", i), {48'd0, w1}, {52'd0, vecs[i].e1});
      check($sformatf("row%0d cs_low", i), 64'(low), 64'd160);
      check($sformatf("row%0d falls", i), 64'(falls), 64'd16);
      check($sformatf("row%0d timing", i), 64'(bad), 64'd0);
      check($sformatf("row%0d handshake", i), 64'(hs), 64'd0);
      if (!vecs[i].rst) check($sformatf("row%0d period", i), 64'(tf - tprev), 64'(1000 * PER));
      tprev = tf;
    end

    // Drop enable at SCK edge 8: frame completes, then no CS until re-enabled
    mode = {2'd1, 2'd0};
    step = {16'h0100, 16'h3000};
    fork
      capture(w0, w1, low, falls, bad, hs, tmo, tf);
      begin
        g = 0;
        while (CS !== 1'b0 && g < 3000) begin
          @(negedge clk_fpga);
          g++;
        end
        repeat (40) @(negedge clk_fpga);
        enable = 1'b0;
      end
    join
    tdrop = tf;
    check("drop timeout", {63'd0, tmo}, 64'd0);
    check("drop ch0", {48'd0, w0}, 64'h0800);
    check("drop ch1", {48'd0, w1}, 64'h0400);
    check("drop cs_low", 64'(low), 64'd160);
    check("drop falls", 64'(falls), 64'd16);
    check("drop timing", 64'(bad + hs), 64'd0);
    seen = 0;
    repeat (1400) begin
      @(negedge clk_fpga);
      if (CS === 1'b0 || busy === 1'b1) seen++;
    end
    check("disabled idle", 64'(seen), 64'd0);
    enable = 1'b1;
    capture(w0, w1, low, falls, bad, hs, tmo, tf);
    check("reenable timeout", {63'd0, tmo}, 64'd0);
    check("reenable wrap", 64'(tf - tdrop), 64'(2000 * PER));
    check("reenable ch0", {48'd0, w0}, 64'h0F63);
    check("reenable ch1", {48'd0, w1}, 64'h0410);

    // Reset mid-shift: outputs idle at once, next frame restarts from phase 0
    g = 0;
    while (CS !== 1'b0 && g < 3000) begin
      @(negedge clk_fpga);
      g++;
    end
    check("pre-reset CS low", {63'd0, CS}, 64'd0);
    repeat (57) @(negedge clk_fpga);
    check("pre-reset DIN", {62'd0, DIN}, 64'd3);
    reset_n = 1'b0;
    #1;
    check("async CS", {63'd0, CS}, 64'd1);
    check("async SCK", {63'd0, SCK}, 64'd1);
    check("async DIN", {62'd0, DIN}, 64'd0);
    check("async busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk_fpga);
    reset_n = 1'b1;
    capture(w0, w1, low, falls, bad, hs, tmo, tf);
    check("post-reset timeout", {63'd0, tmo}, 64'd0);
    check("post-reset ch0", {48'd0, w0}, 64'h0800);
    check("post-reset ch1", {48'd0, w1}, 64'h0000);
    check("post-reset cs_low", 64'(low), 64'd160);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_wave_gen.md
Name: dac_wave_gen

Overview:
- Multi-channel SPI DAC waveform generator. It is the parametrised successor of the team's single-channel sine-table DAC driver.
- Drives a shared active-low CS and SCK, plus one DIN line per DAC channel (e.g. a dual-DAC Pmod), at a fixed sample rate.
- Each channel has its own phase accumulator (frequency control) and its own waveform mode: sine, sawtooth, triangle or square.
- Sits beside the VGA/7-seg logic in the top level, clocked from clk_fpga.

Parameters:
- CHANNELS, 2, number of DAC channels (DIN lines).
- DATA_W, 12, DAC sample width.
- CTRL_W, 4, leading zero control bits per frame; FRAME_W = CTRL_W+DATA_W (16).
- PHASE_W, 16, phase accumulator width; must be >= DATA_W+1.
- ROM_AW, 4, sine table address width (2^ROM_AW entries).
- CLK_DIV, 5, clk_fpga cycles per SCK half-period (100 MHz -> 10 MHz SCK).
- FRAME_CYCLES, 1000, clk_fpga cycles per sample period (100 kHz); must be >= 2*CLK_DIV*FRAME_W+4.

Ports:
- clk_fpga  in  1  system clock, all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run generator.
- mode  in  2*CHANNELS  per-channel mode: 0 sine, 1 sawtooth, 2 triangle, 3 square.
- step  in  PHASE_W*CHANNELS  per-channel phase increment per frame.
- CS  out  1  active-low frame select.
- SCK  out  1  serial clock, idles high.
- DIN  out  CHANNELS  serial data, MSB first.
- busy  out  1  high from LOAD through DONE.
- frame_done  out  1  one-cycle pulse at end of each frame.

Behaviour:
- Reset (async, reset_n=0):
  - CS=1, SCK=1, DIN=0, busy=0, frame_done=0.
  - All phase accumulators, the frame counter and the divider clear to 0.
  - FSM goes to IDLE.
  - A reset mid-shift aborts the frame immediately; no partial-frame recovery.
- Frame counter: runs 0..FRAME_CYCLES-1 and wraps, whenever reset_n=1.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE -> LOAD when enable=1 and the frame counter is 0.
  - LOAD (1 cycle):
    - Samples mode and step for all channels.
    - Computes each channel's sample from its current phase.
    - Loads shift register {CTRL_W'b0, sample}.
    - Drives DIN = bit FRAME_W-1 and CS=0.
  - SHIFT:
    - SCK toggles every CLK_DIV cycles, starting with a falling edge CLK_DIV cycles after LOAD.
    - DIN updates on each SCK rising edge and is stable across each falling edge (DAC samples on falling).
    - After exactly FRAME_W falling edges and the following rising edge -> DONE.
    - CS is therefore low for 2*CLK_DIV*FRAME_W cycles.
  - DONE (1 cycle):
    - CS=1, SCK=1, DIN=0, frame_done=1.
    - Each phase += its latched step, modulo 2^PHASE_W.
    - -> IDLE.
- enable deasserted mid-frame: the current frame completes normally; no new LOAD.
- mode/step changes outside LOAD: no effect until the next LOAD.
- Sample computation (P = phase):
  - sine = SINE_ROM[P[PHASE_W-1 -: ROM_AW]].
  - sawtooth = P[PHASE_W-1 -: DATA_W].
  - triangle = P[PHASE_W-1] ? ~P[PHASE_W-2 -: DATA_W] : P[PHASE_W-2 -: DATA_W].
  - square = P[PHASE_W-1] ? all ones : 0.
- SINE_ROM[k] = round-half-up((2^DATA_W-1)/2 * (1+sin(2*pi*k/2^ROM_AW))). The table is computed at elaboration; there is no hand-entered table.
- All channels share CS/SCK and shift in lockstep.

Decomposition:
- Package dac_wave_pkg:
  - mode encodings (MODE_SINE, MODE_SAW, MODE_TRI, MODE_SQR).
  - FSM state encodings.
  - sine-table constant function.
- One sub-module, dac_wave_sample: combinational phase+mode -> DATA_W sample, including the ROM. Instantiated CHANNELS times.
- The SPI FSM and divider stay in the top.

Test Plan:
- Defaults, enable=1, ch0 sine, step=0x1000 -> frame0 word 0x0800, frame1 0x0B0F, frame4 0x0FFF, frame12 0x0000.
- ch1 sawtooth, step=0x0100 -> frame n data = 16*n (0x000, 0x010, 0x020...). Wraps to 0x000 at frame 256.
- Timing check:
  - CS low exactly 160 cycles per frame.
  - Exactly 16 SCK falling edges while CS low; DIN stable 5 cycles either side of each falling edge.
  - Frame period 1000 cycles; frame_done single-cycle pulse 1 cycle after CS rises.
- ch0 square step=0x8000 and ch1 triangle step=0x4000 simultaneously:
  - ch0 alternates 0x000/0xFFF.
  - ch1 gives 0x000, 0x800, 0xFFF, 0x7FF.
- Drop enable at SCK edge 8 -> the frame finishes with all 16 bits and no further CS. Re-assert -> next LOAD at the frame counter's next wrap.
- Pull reset_n low mid-SHIFT -> CS=1, SCK=1, DIN=0 without waiting for a clock edge. After release, the first frame is phase 0 (sine 0x0800).
